picomips_ctrl_datapath: RTL and testbench
=========================================

Name: picomips_ctrl_datapath

Overview:
- Combined program-counter, instruction-decoder and ALU slice of the picoMIPS core.
- The PC addresses program memory.
- The returned instruction word is split combinationally into opcode, signed address offset and coefficient index.
- The ALU performs the fixed-point multiply and accumulate-add used by the core FSM to run a waveform FIR-style sum.

Parameters:
- PC_WIDTH, 6, program counter width (64-entry program memory).
- I_WIDTH, 8, instruction width; field layout below is fixed for 8.
- DATA_WIDTH, 8, ALU operand/result width (signed two's complement, Q1.7 for multiply).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- pc_clr  input  1  synchronous PC clear.
- pc_incr  input  1  synchronous PC increment enable.
- pc  output  PC_WIDTH  current program counter.
- instruction  input  I_WIDTH  word read from program memory at pc.
- opcode  output  2  decoded opcode.
- offset  output  3  signed waveform address offset.
- imm  output  3  coefficient index.
- is_end  output  1  high when opcode is END or illegal.
- alu_a  input  DATA_WIDTH  operand A.
- alu_b  input  DATA_WIDTH  operand B.
- alu_func  input  2  ALU function select.
- alu_result  output  DATA_WIDTH  combinational ALU result.

Behaviour:

Program counter:
- The PC is the only state in the block.
- reset=0 clears pc to 0 immediately, independent of clk.
- On rising clk with reset=1:
  - if pc_clr=1, pc <= 0 (pc_clr has priority over pc_incr);
  - else if pc_incr=1, pc <= pc+1;
  - else pc holds.
- Wrap-around: pc 63 + incr -> 0; no flag.
- pc_incr held high for N cycles advances pc by N.
- Reset deasserted mid-program restarts at 0; pc_clr and pc_incr are ignored while reset=0.

Decoder (purely combinational, zero latency):
- opcode = instruction[7:6].
- offset = instruction[5:3], interpreted as signed, range -4..+3.
- imm = instruction[2:0].
- Opcode encoding: 2'b00 NOP/illegal, 2'b01 MUL, 2'b10 ADD, 2'b11 END.
- is_end = 1 for opcodes 00 and 11, so illegal words halt the core.

ALU (purely combinational, result valid the same cycle):
- alu_func encoding: 00 ALU_ADD, 01 ALU_MUL, 10 PASS_A, 11 ZERO.
- ALU_ADD: result = (alu_a + alu_b) mod 256. Two's-complement wrap, no saturation: 0x7F+0x01 = 0x80.
- ALU_MUL: signed 8x8 multiply, 16-bit product P; result = P[14:7] (Q1.7 x Q1.7 -> Q1.7, truncation toward -inf).
  - Single overflow case: -128 x -128 saturates to 0x7F.
- PASS_A: result = alu_a.
- ZERO: result = 0x00.
- No flags and no internal registers in the ALU.
- The ALU and decoder are unaffected by reset; outputs track their inputs at all times.

Test Plan:
- Reset/PC: drive reset=0 mid-cycle with pc=5 -> pc=0 without a clock edge. Release, pc_incr=1 for 3 cycles -> pc=3. pc_clr=1 with pc_incr=1 -> pc=0.
- PC wrap: preload by 63 increments, one more increment -> pc=0. pc_incr=0 -> pc holds across 4 cycles.
- Decoder: instruction 0x6D (01_101_101) -> opcode=MUL, offset=-3, imm=5, is_end=0. 0x80 -> ADD, offset 0, imm 0. 0xC0 -> END, is_end=1. 0x00 -> is_end=1.
- ALU add: 0x10+0x20 -> 0x30; 0x7F+0x01 -> 0x80; 0xFF+0x01 -> 0x00.
- ALU multiply: 0x40x0x40 -> 0x20; 0x40x0xC0 -> 0xE0; 0x7Fx0x7F -> 0x7E; 0x80x0x80 -> 0x7F (saturated); 0x00xany -> 0x00.
- ALU misc: PASS_A with a=0x5A -> 0x5A; ZERO -> 0x00. Change alu_func with operands fixed -> result updates the same cycle.

Source files
------------

// File: rtl/picomips_ctrl_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module      : picomips_ctrl_datapath_if
//  Description : Bus bundle for the picoMIPS PC / decoder / ALU slice.
//                Groups the PC control, the program-memory instruction path,
//                the decoded fields and the ALU operand/result signals.
//  Modports    : master - core FSM side (drives controls, operands, instr)
//                slave  - datapath side (drives pc, decoded fields, result)
//  Revision    : 1.0 - initial release
// ============================================================================
interface picomips_ctrl_datapath_if #(
    parameter int PC_WIDTH   = 6,
    parameter int I_WIDTH    = 8,
    parameter int DATA_WIDTH = 8
);
    // PC control and program-memory address
    logic                  pc_clr;
    logic                  pc_incr;
    logic [PC_WIDTH-1:0]   pc;

    // Instruction word and decoded fields
    logic [I_WIDTH-1:0]    instruction;
    logic [1:0]            opcode;
    logic [2:0]            offset;
    logic [2:0]            imm;
    logic                  is_end;

    // ALU
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [1:0]            alu_func;
    logic [DATA_WIDTH-1:0] alu_result;

    modport master (
        output pc_clr, pc_incr, instruction, alu_a, alu_b, alu_func,
        input  pc, opcode, offset, imm, is_end, alu_result
    );

    modport slave (
        input  pc_clr, pc_incr, instruction, alu_a, alu_b, alu_func,
        output pc, opcode, offset, imm, is_end, alu_result
    );
endinterface
`default_nettype wire

// File: rtl/picomips_ctrl_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : picomips_ctrl_datapath
//  Description : Program counter, instruction decoder and fixed-point ALU
//                slice of the picoMIPS core.
//  Ports       : clk    - system clock, rising edge
//                reset  - asynchronous active-low reset (clears pc only)
//                bus    - slave modport of picomips_ctrl_datapath_if:
//                         pc_clr/pc_incr -> pc, instruction -> opcode/offset/
//                         imm/is_end, alu_a/alu_b/alu_func -> alu_result
//  Revision    : 1.0 - initial release
// ============================================================================
module picomips_ctrl_datapath #(
    parameter int PC_WIDTH   = 6,
    parameter int I_WIDTH    = 8,
    parameter int DATA_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    picomips_ctrl_datapath_if.slave    bus
);

    localparam logic [1:0] c_OP_NOP   = 2'b00;
    localparam logic [1:0] c_OP_END   = 2'b11;

    localparam logic [1:0] c_ALU_ADD  = 2'b00;
    localparam logic [1:0] c_ALU_MUL  = 2'b01;
    localparam logic [1:0] c_ALU_PASS = 2'b10;
    localparam logic [1:0] c_ALU_ZERO = 2'b11;

    localparam logic [DATA_WIDTH-1:0] c_Q_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    // ------------------------------------------------------------------
    // Program counter (the only state in this block)
    // ------------------------------------------------------------------
    logic [PC_WIDTH-1:0] r_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= '0;
        end else if (bus.pc_clr) begin
            r_pc <= '0;
        end else if (bus.pc_incr) begin
            r_pc <= r_pc + 1'b1;   // natural wrap from all-ones to zero
        end
    end

    assign bus.pc = r_pc;

    // ------------------------------------------------------------------
    // Decoder: fixed field layout for an 8-bit word
    //   [7:6] opcode, [5:3] signed offset, [2:0] coefficient index
    // ------------------------------------------------------------------
    logic [1:0] w_opcode;

    assign w_opcode   = bus.instruction[7:6];
    assign bus.opcode = w_opcode;
    assign bus.offset = bus.instruction[5:3];
    assign bus.imm    = bus.instruction[2:0];
    // NOP doubles as the illegal encoding, so it halts the core like END
    assign bus.is_end = (w_opcode == c_OP_NOP) || (w_opcode == c_OP_END);

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    // w_mul_q holds product bits [2*DW-1:DW-1]: the Q1.7 result plus the
    // product sign bit. An arithmetic right shift floors toward -inf.
    logic signed [DATA_WIDTH:0]   w_mul_q;
    logic                         w_mul_ovf;
    logic        [DATA_WIDTH-1:0] w_mul_res;
    logic        [DATA_WIDTH-1:0] w_alu_res;

    assign w_mul_q = (DATA_WIDTH+1)'(
                         (2*DATA_WIDTH)'($signed(bus.alu_a) * $signed(bus.alu_b))
                         >>> (DATA_WIDTH-1));

    // The only product that does not fit Q1.7 is (-1.0)*(-1.0) = +1.0,
    // which shows up as the kept sign bit disagreeing with the top kept bit.
    assign w_mul_ovf = w_mul_q[DATA_WIDTH] ^ w_mul_q[DATA_WIDTH-1];
    assign w_mul_res = w_mul_ovf ? c_Q_MAX : w_mul_q[DATA_WIDTH-1:0];

    always_comb begin
        w_alu_res = '0;
        case (bus.alu_func)
            c_ALU_ADD:  w_alu_res = bus.alu_a + bus.alu_b;
            c_ALU_MUL:  w_alu_res = w_mul_res;
            c_ALU_PASS: w_alu_res = bus.alu_a;
            c_ALU_ZERO: w_alu_res = '0;
            default:    w_alu_res = '0;
        endcase
    end

    assign bus.alu_result = w_alu_res;

endmodule
`default_nettype wire

// File: tb/tb_picomips_ctrl_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_picomips_ctrl_datapath
//  Description : Scoreboard bench for picomips_ctrl_datapath. The driver
//                applies one input set per cycle just after the rising edge
//                and queues the reference-model expectation; the monitor
//                pops and compares on each falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_picomips_ctrl_datapath;

    logic clk;
    logic reset;

    picomips_ctrl_datapath_if #(.PC_WIDTH(6), .I_WIDTH(8), .DATA_WIDTH(8)) bus ();

    picomips_ctrl_datapath #(.PC_WIDTH(6), .I_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int opcode;
        int offset;
        int imm;
        int is_end;
        int alu;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   m_pc   = 0;     // reference program counter

    // ---------------- reference model ----------------
    function automatic int ref_alu(input int a, input int b, input int f);
        int sa, sb, p, r;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (f)
            0: r = (a + b) % 256;
            1: begin
                p = sa * sb;
                // floor division by 128
                r = p / 128;
                if (p < 0 && (p % 128) != 0) r = r - 1;
                if (r > 127) r = 127;
                r = (r + 256) % 256;
            end
            2: r = a;
            default: r = 0;
        endcase
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit rst_v, input bit clr, input bit inc,
                         input int ins, input int a, input int b, input int f);
        exp_t e;
        int   fld;
        @(posedge clk);
        #1;
        reset           = rst_v;
        bus.pc_clr      = clr;
        bus.pc_incr     = inc;
        bus.instruction = 8'(ins);
        bus.alu_a       = 8'(a);
        bus.alu_b       = 8'(b);
        bus.alu_func    = 2'(f);

        if (!rst_v) m_pc = 0;           // asynchronous clear, no edge needed
        e.pc     = m_pc;
        e.opcode = ins / 64;
        fld      = (ins / 8) % 8;
        e.offset = (fld >= 4) ? fld - 8 : fld;
        e.imm    = ins % 8;
        e.is_end = (e.opcode == 0 || e.opcode == 3) ? 1 : 0;
        e.alu    = ref_alu(a, b, f);
        q.push_back(e);

        // state seen after the next rising edge
        if (rst_v) begin
            if (clr)      m_pc = 0;
            else if (inc) m_pc = (m_pc + 1) % 64;
        end
    endtask

    // ---------------- monitor ----------------
    task automatic cmp(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, $time, act, act, req, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("pc",     int'(bus.pc),              e.pc);
            cmp("opcode", int'(bus.opcode),          e.opcode);
            cmp("offset", int'($signed(bus.offset)), e.offset);
            cmp("imm",    int'(bus.imm),             e.imm);
            cmp("is_end", int'(bus.is_end),          e.is_end);
            cmp("alu",    int'(bus.alu_result),      e.alu);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wait_cnt;
        reset = 1'b0;
        bus.pc_clr = 1'b0; bus.pc_incr = 1'b0;
        bus.instruction = '0; bus.alu_a = '0; bus.alu_b = '0; bus.alu_func = '0;

        // reset state, with controls that must be ignored
        drive(0, 0, 1, 8'h6D, 8'h10, 8'h20, 0);
        drive(0, 1, 1, 8'h80, 8'h7F, 8'h01, 0);
        // advance to pc=5, then async reset mid-cycle
        repeat (5) drive(1, 0, 1, 8'hC0, 8'hFF, 8'h01, 0);
        drive(0, 0, 1, 8'h00, 8'h40, 8'h40, 1);
        // release, 3 increments -> 3
        repeat (3) drive(1, 0, 1, 8'h6D, 8'h40, 8'hC0, 1);
        drive(1, 1, 1, 8'h80, 8'h7F, 8'h7F, 1);   // observe pc=3, clr wins
        drive(1, 0, 0, 8'hC0, 8'h80, 8'h80, 1);   // pc=0, saturating multiply
        // wrap: 63 increments then one more
        for (int i = 0; i < 64; i++)
            drive(1, 0, 1, 8'h00, 8'h00, $urandom_range(0, 255), 1);
        // hold for 4 cycles; sweep alu_func with fixed operands
        for (int f = 0; f < 4; f++) drive(1, 0, 0, 8'h6D, 8'h5A, 8'h33, f);
        drive(1, 0, 0, 8'h6D, 8'h5A, 8'h33, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) != 0),
                  ($urandom_range(0, 15) == 0),
                  $urandom_range(0, 1),
                  $urandom_range(0, 255),
                  $urandom_range(0, 255),
                  $urandom_range(0, 255),
                  $urandom_range(0, 3));
        end
        drive(1, 0, 0, 8'h80, 8'h80, 8'h80, 1);

        // drain the scoreboard with a bounded wait
        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        n_vec++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
